// File: rtl/exec_pkg.sv
// Shared types and constants for the execute/memory stage and its function unit.
package exec_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  // Bit positions inside the 4-bit flag word {V,C,N,Z}.
  localparam int FLAG_V = 3;
  localparam int FLAG_C = 2;
  localparam int FLAG_N = 1;
  localparam int FLAG_Z = 0;

  localparam logic ERR_NONE = 1'b0;
  localparam logic ERR_SET  = 1'b1;
  localparam logic WB_NONE  = 1'b0;
  localparam logic WB_REG   = 1'b1;

  // Function-unit operation selects (fs field).
  localparam logic [3:0] FS_ADD = 4'd0;
  localparam logic [3:0] FS_SUB = 4'd1;
  localparam logic [3:0] FS_AND = 4'd2;
  localparam logic [3:0] FS_OR  = 4'd3;
  localparam logic [3:0] FS_XOR = 4'd4;
  localparam logic [3:0] FS_SLL = 4'd5;
  localparam logic [3:0] FS_SRL = 4'd6;
  localparam logic [3:0] FS_SRA = 4'd7;
  localparam logic [3:0] FS_SLT = 4'd8;

  // Upper-immediate opcode: the unit just forwards operand B.
  localparam logic [6:0] OPC_LUI = 7'h37;

endpackage

// File: rtl/exec_mem_stage_function_unit.sv
// Combinational 32-bit function unit: arithmetic, logic, shifts, set-less-than.
// Carry/overflow are meaningful only for add/sub; N and Z track the result.
module FunctionUnit
  import exec_pkg::*;
(
  input  logic [6:0]  opcode,
  input  logic [3:0]  fs,
  input  logic [4:0]  sh,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] fout,
  output logic [3:0]  flags
);

  // Select the operation result and its carry/overflow.
  always_comb begin
    logic [32:0] sum;
    logic [32:0] diff;
    logic        c;
    logic        v;
    sum  = {1'b0, a} + {1'b0, b};
    diff = {1'b0, a} + {1'b0, ~b} + 33'd1;
    fout = 32'd0;
    c    = 1'b0;
    v    = 1'b0;
    if (opcode == OPC_LUI) begin
      fout = b;
    end else begin
      case (fs)
        FS_ADD: begin
          fout = sum[31:0];
          c    = sum[32];
          v    = (a[31] == b[31]) && (sum[31] != a[31]);
        end
        FS_SUB: begin
          fout = diff[31:0];
          c    = diff[32];
          v    = (a[31] != b[31]) && (diff[31] != a[31]);
        end
        FS_AND:  fout = a & b;
        FS_OR:   fout = a | b;
        FS_XOR:  fout = a ^ b;
        FS_SLL:  fout = a << sh;
        FS_SRL:  fout = a >> sh;
        FS_SRA:  fout = $unsigned($signed(a) >>> sh);
        FS_SLT:  fout = {31'd0, ($signed(a) < $signed(b))};
        default: fout = b;
      endcase
    end
    flags         = 4'd0;
    flags[FLAG_V] = v;
    flags[FLAG_C] = c;
    flags[FLAG_N] = fout[31];
    flags[FLAG_Z] = (fout == 32'd0);
  end

endmodule

// File: rtl/exec_mem_stage.sv
// Execute/memory stage: one op in flight. ALU ops finish in one cycle; loads and
// stores go through a req/gnt/rvalid port with a bounded wait for read data.
// Handshakes: a transfer happens on a rising edge where valid & ready are both 1;
// in_ready depends only on state and out_ready; out_* hold while out_valid & !out_ready.
module exec_mem_stage
  import exec_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 11,
  parameter int BYTE_ADDR = 0,
  parameter int TIMEOUT   = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [6:0]        in_opcode,
  input  logic [3:0]        in_fs,
  input  logic [4:0]        in_sh,
  input  logic [DATA_W-1:0] in_bus_a,
  input  logic [DATA_W-1:0] in_bus_b,
  input  logic              in_mr,
  input  logic              in_mw,
  input  logic [4:0]        in_rd,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [4:0]        out_rd,
  output logic              out_wb,
  output logic [3:0]        out_flags,
  output logic              out_err,
  output logic              dm_req,
  output logic              dm_we,
  output logic [ADDR_W-1:0] dm_addr,
  output logic [DATA_W-1:0] dm_wdata,
  input  logic              dm_gnt,
  input  logic              dm_rvalid,
  input  logic [DATA_W-1:0] dm_rdata
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  state_t              state, state_d;
  logic [CNT_W-1:0]    cnt, cnt_d;
  logic [DATA_W-1:0]   data_d, wdata_d;
  logic [4:0]          rd_d;
  logic                wb_d, err_d, req_d, we_d;
  logic [3:0]          flags_d;
  logic [ADDR_W-1:0]   addr_d;
  logic [ADDR_W-1:0]   word_addr;
  logic                misaligned;
  logic                accept;
  logic [31:0]         fu_out;
  logic [3:0]          fu_flags;

  FunctionUnit u_fu (
    .opcode (in_opcode),
    .fs     (in_fs),
    .sh     (in_sh),
    .a      (32'(in_bus_a)),
    .b      (32'(in_bus_b)),
    .fout   (fu_out),
    .flags  (fu_flags)
  );

  // Byte addressing drops the two low bits and flags them when non-zero.
  generate
    if (BYTE_ADDR != 0) begin : g_byte_addr
      assign word_addr  = in_bus_a[ADDR_W+1:2];
      assign misaligned = |in_bus_a[1:0];
    end else begin : g_word_addr
      assign word_addr  = in_bus_a[ADDR_W-1:0];
      assign misaligned = 1'b0;
    end
  endgenerate

  assign in_ready  = (state == ST_IDLE) || ((state == ST_DONE) && out_ready);
  assign accept    = in_valid && in_ready;
  assign out_valid = (state == ST_DONE);

  // Next-state and next-register values; everything holds unless changed below.
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    data_d  = out_data;
    rd_d    = out_rd;
    wb_d    = out_wb;
    flags_d = out_flags;
    err_d   = out_err;
    req_d   = dm_req;
    we_d    = dm_we;
    addr_d  = dm_addr;
    wdata_d = dm_wdata;
    case (state)
      ST_IDLE, ST_DONE: begin
        if (accept) begin
          rd_d    = in_rd;
          data_d  = '0;
          flags_d = '0;
          wb_d    = WB_NONE;
          err_d   = ERR_NONE;
          if ((in_mr && in_mw) || ((in_mr || in_mw) && misaligned)) begin
            err_d   = ERR_SET;
            state_d = ST_DONE;
          end else if (in_mr || in_mw) begin
            req_d   = 1'b1;
            we_d    = in_mw;
            addr_d  = word_addr;
            wdata_d = in_mw ? in_bus_b : '0;
            state_d = ST_REQ;
          end else begin
            data_d  = DATA_W'(fu_out);
            flags_d = fu_flags;
            wb_d    = WB_REG;
            state_d = ST_DONE;
          end
        end else if ((state == ST_DONE) && out_ready) begin
          state_d = ST_IDLE;
        end
      end
      ST_REQ: begin
        if (dm_gnt) begin
          req_d = 1'b0;
          we_d  = 1'b0;
          if (dm_we) begin
            state_d = ST_DONE;
          end else if (dm_rvalid) begin
            data_d  = dm_rdata;
            wb_d    = WB_REG;
            state_d = ST_DONE;
          end else begin
            cnt_d   = '0;
            state_d = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        cnt_d = cnt + CNT_W'(1);
        if (dm_rvalid) begin
          data_d  = dm_rdata;
          wb_d    = WB_REG;
          state_d = ST_DONE;
        end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
          err_d   = ERR_SET;
          state_d = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, counter and all registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      out_data  <= '0;
      out_rd    <= '0;
      out_wb    <= 1'b0;
      out_flags <= '0;
      out_err   <= 1'b0;
      dm_req    <= 1'b0;
      dm_we     <= 1'b0;
      dm_addr   <= '0;
      dm_wdata  <= '0;
    end else begin
      state     <= state_d;
      cnt       <= cnt_d;
      out_data  <= data_d;
      out_rd    <= rd_d;
      out_wb    <= wb_d;
      out_flags <= flags_d;
      out_err   <= err_d;
      dm_req    <= req_d;
      dm_we     <= we_d;
      dm_addr   <= addr_d;
      dm_wdata  <= wdata_d;
    end
  end

endmodule
